// File: rtl/ddr2_wr_frontend.sv
// Write-path front end: buffers user write commands/data and splits bursts into controller chunks.
// Latency: chunk issue starts 3 cycles after its command reaches the FIFO head with data buffered.
// Backpressure: usr_cmd_ready/usr_wready drop when the FIFOs are full; awready/wready/bvalid pace the chunks.

// Generic FIFO: registered pointers, occupancy count, no internal overflow guard.
module ddr2_wr_frontend_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // Storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign dout = mem[rp];
endmodule

module ddr2_wr_frontend #(
  parameter int BA_BITS    = 3,
  parameter int ROW_BITS   = 13,
  parameter int COL_BITS   = 10,
  parameter int DQ_BITS    = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 init_end,
  input  logic                                 usr_cmd_valid,
  output logic                                 usr_cmd_ready,
  input  logic [BA_BITS+ROW_BITS+COL_BITS-1:0] usr_addr,
  input  logic [7:0]                           usr_len,
  input  logic                                 usr_wvalid,
  output logic                                 usr_wready,
  input  logic [DQ_BITS*2-1:0]                 usr_wdata,
  input  logic                                 usr_wlast,
  output logic                                 usr_done,
  output logic                                 usr_err_odd,
  output logic                                 awvalid,
  input  logic                                 awready,
  output logic [BA_BITS+ROW_BITS+COL_BITS-1:0] awaddr,
  output logic [7:0]                           awlen,
  output logic                                 wvalid,
  input  logic                                 wready,
  output logic                                 wlast,
  output logic [DQ_BITS*2-1:0]                 wdata,
  input  logic                                 bvalid,
  output logic                                 bready
);
  localparam int AW    = BA_BITS + ROW_BITS + COL_BITS;
  localparam int BW    = DQ_BITS * 2;
  localparam int CCW   = $clog2(CMD_DEPTH + 1);
  localparam int DCW   = $clog2(DATA_DEPTH + 1);
  localparam int CMD_W = AW + 8 + 1;

  typedef enum logic [2:0] {S_IDLE, S_SPLIT, S_WAIT, S_ISSUE, S_DATA, S_RESP} state_t;

  state_t        state, nxt;
  logic          rdy_en;
  logic          pad_pending;
  logic [CCW-1:0] cmd_cnt, pad_cnt;
  logic [DCW-1:0] data_cnt;
  logic [CMD_W-1:0] cmd_dout;
  logic          pad_dout;
  logic [BW-1:0] data_dout;
  logic          cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic          usr_push, pad_push, data_push, data_pop, data_full;
  logic          pad_pop;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [AW-1:0] cur_addr;
  logic [8:0]    rem, chunk, chunk_calc;
  logic [7:0]    beat_cnt;

  assign cmd_full  = (cmd_cnt == CCW'(CMD_DEPTH));
  assign cmd_empty = (cmd_cnt == '0);
  assign data_full = (data_cnt == DCW'(DATA_DEPTH));

  assign usr_cmd_ready = rdy_en && !cmd_full;
  assign usr_wready    = rdy_en && !data_full && !pad_pending;
  assign cmd_push      = usr_cmd_valid && usr_cmd_ready;
  assign usr_push      = usr_wvalid && usr_wready;
  // Pad bits follow the data side, which may run ahead of the chunk engine.
  assign pad_pop       = usr_push && usr_wlast && (pad_cnt != '0);
  assign pad_push      = pad_pending && !data_full;
  assign data_push     = usr_push || pad_push;
  assign data_pop      = wvalid && wready;

  assign cmd_addr = cmd_dout[CMD_W-1 -: AW];
  assign cmd_len  = cmd_dout[8:1];

  ddr2_wr_frontend_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n), .push(cmd_push),
    .din({usr_addr & {{(AW-2){1'b1}}, 2'b00}, usr_len | 8'd1, ~usr_len[0]}),
    .pop(cmd_pop), .dout(cmd_dout), .count(cmd_cnt)
  );

  ddr2_wr_frontend_fifo #(.W(1), .DEPTH(CMD_DEPTH)) u_pad_fifo (
    .clk(clk), .rst_n(rst_n), .push(cmd_push), .din(~usr_len[0]),
    .pop(pad_pop), .dout(pad_dout), .count(pad_cnt)
  );

  ddr2_wr_frontend_fifo #(.W(BW), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(clk), .rst_n(rst_n), .push(data_push),
    .din(pad_pending ? '0 : usr_wdata),
    .pop(data_pop), .dout(data_dout), .count(data_cnt)
  );

  // Ready enable keeps both user readies low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Zero-beat padding after an odd-length command's last beat; sticky odd flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_pending <= 1'b0;
      usr_err_odd <= 1'b0;
    end else begin
      if (pad_push)                        pad_pending <= 1'b0;
      else if (pad_pop && pad_dout)        pad_pending <= 1'b1;
      if (cmd_push && !usr_len[0])         usr_err_odd <= 1'b1;
    end
  end

  // Chunk size: bounded by remaining beats, MAX_BEATS and beats left in the row.
  always_comb begin
    logic [31:0] room_w, ch_w;
    room_w = ((32'd1 << COL_BITS) - 32'(cur_addr[COL_BITS-1:0])) >> 1;
    ch_w   = 32'(rem);
    if (ch_w > 32'(MAX_BEATS)) ch_w = 32'(MAX_BEATS);
    if (ch_w > room_w)         ch_w = room_w;
    chunk_calc = ch_w[8:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // FSM next state and controller-side handshake outputs.
  always_comb begin
    nxt     = state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    cmd_pop = 1'b0;
    case (state)
      S_IDLE:  if (init_end && !cmd_empty) nxt = S_SPLIT;
      S_SPLIT: nxt = S_WAIT;
      S_WAIT:  if (32'(data_cnt) >= 32'(chunk)) nxt = S_ISSUE;
      S_ISSUE: begin
        awvalid = 1'b1;
        if (awready) nxt = S_DATA;
      end
      S_DATA: begin
        wvalid = 1'b1;
        wlast  = (beat_cnt == 8'(chunk - 9'd1));
        if (wready && wlast) nxt = S_RESP;
      end
      S_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          if (rem == chunk) begin
            cmd_pop = 1'b1;
            nxt     = S_IDLE;
          end else begin
            nxt = S_SPLIT;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Chunk datapath: address/remaining tracking, beat counter, completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      rem      <= '0;
      chunk    <= '0;
      beat_cnt <= '0;
      usr_done <= 1'b0;
    end else begin
      usr_done <= cmd_pop;
      case (state)
        S_IDLE: if (init_end && !cmd_empty) begin
          cur_addr <= cmd_addr;
          rem      <= {1'b0, cmd_len} + 9'd1;
        end
        S_SPLIT: begin
          chunk    <= chunk_calc;
          beat_cnt <= '0;
        end
        S_DATA: if (data_pop) beat_cnt <= beat_cnt + 8'd1;
        S_RESP: if (bvalid) begin
          cur_addr <= cur_addr + AW'({chunk, 1'b0});
          rem      <= rem - chunk;
        end
        default: ;
      endcase
    end
  end

  assign awaddr = awvalid ? cur_addr : '0;
  assign awlen  = awvalid ? 8'(chunk - 9'd1) : 8'd0;
  assign wdata  = wvalid ? data_dout : '0;
endmodule

// File: tb/tb_ddr2_wr_frontend.sv
// Directed bench for ddr2_wr_frontend: table of user commands with expected chunking,
// plus hand sequences for init gating, data starvation and reset in mid-burst.
module tb_ddr2_wr_frontend;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_end;
  logic        usr_cmd_valid;
  logic        usr_cmd_ready;
  logic [25:0] usr_addr;
  logic [7:0]  usr_len;
  logic        usr_wvalid;
  logic        usr_wready;
  logic [15:0] usr_wdata;
  logic        usr_wlast;
  logic        usr_done;
  logic        usr_err_odd;
  logic        awvalid, awready;
  logic [25:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready, wlast;
  logic [15:0] wdata;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  ddr2_wr_frontend dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end),
    .usr_cmd_valid(usr_cmd_valid), .usr_cmd_ready(usr_cmd_ready),
    .usr_addr(usr_addr), .usr_len(usr_len),
    .usr_wvalid(usr_wvalid), .usr_wready(usr_wready), .usr_wdata(usr_wdata), .usr_wlast(usr_wlast),
    .usr_done(usr_done), .usr_err_odd(usr_err_odd),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0]       addr;
    logic [7:0]        len;
    logic [2:0]        nch;
    logic [3:0][25:0]  ea;
    logic [3:0][7:0]   el;
    logic              err;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [25:0] A(input int ba, input int row, input int col);
    logic [2:0] b; logic [12:0] r; logic [9:0] c;
    b = 3'(ba); r = 13'(row); c = 10'(col);
    return {b, r, c};
  endfunction

  function automatic vec_t mkv(input logic [25:0] addr, input logic [7:0] len, input logic [2:0] nch,
                               input logic [25:0] a0, input logic [25:0] a1,
                               input logic [25:0] a2, input logic [25:0] a3,
                               input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] l3, input logic err);
    vec_t v;
    v.addr = addr; v.len = len; v.nch = nch;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.el[0] = l0; v.el[1] = l1; v.el[2] = l2; v.el[3] = l3;
    v.err = err;
    return v;
  endfunction

  function automatic logic [15:0] pat(input int vi, input int k);
    logic [3:0] a; logic [7:0] b;
    a = 4'(vi); b = 8'(k);
    return {a, 4'hA, b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_cmd(input vec_t v);
    int t = 0;
    usr_cmd_valid = 1'b1; usr_addr = v.addr; usr_len = v.len;
    while (!usr_cmd_ready && t < 500) begin @(negedge clk); t++; end
    chk("cmd_ready", usr_cmd_ready, 1);
    @(negedge clk);
    usr_cmd_valid = 1'b0;
  endtask

  task automatic produce(input vec_t v, input int vi, input int from, input int upto);
    int nb = int'(v.len) + 1;
    for (int k = from; k < upto; k++) begin
      int t = 0;
      usr_wvalid = 1'b1; usr_wdata = pat(vi, k); usr_wlast = (k == nb - 1);
      while (!usr_wready && t < 2000) begin @(negedge clk); t++; end
      chk("wready_wait", usr_wready, 1);
      @(negedge clk);
    end
    usr_wvalid = 1'b0; usr_wlast = 1'b0; usr_wdata = '0;
    if (upto == nb && !v.len[0]) chk("pad_wready_low", usr_wready, 0);
  endtask

  task automatic consume(input vec_t v, input int vi);
    int nb = int'(v.len) + 1;
    int k = 0;
    for (int c = 0; c < int'(v.nch); c++) begin
      int t = 0;
      while (!awvalid && t < 2000) begin @(negedge clk); t++; end
      chk("awvalid", awvalid, 1);
      chk("awaddr", awaddr, v.ea[c]);
      chk("awlen", awlen, v.el[c]);
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0; wready = 1'b1;
      for (int j = 0; j <= int'(v.el[c]); j++) begin
        logic [15:0] ed;
        logic el;
        ed = (k < nb) ? pat(vi, k) : 16'h0;
        el = (j == int'(v.el[c]));
        chk("wbeat", {wvalid, wlast, wdata}, {1'b1, el, ed});
        k++;
        @(negedge clk);
      end
      wready = 1'b0;
      chk("bready", {wvalid, bready}, 2'b01);
      bvalid = 1'b1;
      @(negedge clk);
      bvalid = 1'b0;
      chk("usr_done", usr_done, (c == int'(v.nch) - 1));
    end
    @(negedge clk);
    chk("usr_done_pulse", usr_done, 0);
  endtask

  initial begin
    vec_t v;
    logic seen;
    int t;

    tbl[0] = mkv(A(1,5,0), 8'd15, 3'd1, A(1,5,0), '0, '0, '0, 8'd15, 0, 0, 0, 1'b0);
    tbl[1] = mkv(A(0,9,1016), 8'd7, 3'd2, A(0,9,1016), A(0,10,0), '0, '0, 8'd3, 8'd3, 0, 0, 1'b0);
    tbl[2] = mkv(A(2,3,0), 8'd63, 3'd4, A(2,3,0), A(2,3,32), A(2,3,64), A(2,3,96),
                 8'd15, 8'd15, 8'd15, 8'd15, 1'b0);
    tbl[3] = mkv(A(3,7,8), 8'd4, 3'd1, A(3,7,8), '0, '0, '0, 8'd5, 0, 0, 0, 1'b1);
    tbl[4] = mkv(A(7,8191,1020), 8'd3, 3'd2, A(7,8191,1020), A(0,0,0), '0, '0, 8'd1, 8'd1, 0, 0, 1'b1);
    tbl[5] = mkv(A(0,1,6), 8'd1, 3'd1, A(0,1,4), '0, '0, '0, 8'd1, 0, 0, 0, 1'b1);

    rst_n = 1'b0; init_end = 1'b0;
    usr_cmd_valid = 1'b0; usr_addr = '0; usr_len = '0;
    usr_wvalid = 1'b0; usr_wdata = '0; usr_wlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {usr_cmd_ready, usr_wready, usr_done, usr_err_odd, awvalid, wvalid, wlast, bready, awaddr, awlen, wdata},
        58'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", {usr_cmd_ready, usr_wready}, 2'b11);

    // Init gating: command and full data buffered, no chunk until init_end.
    v = mkv(A(1,2,0), 8'd7, 3'd1, A(1,2,0), '0, '0, '0, 8'd7, 0, 0, 0, 1'b0);
    push_cmd(v);
    produce(v, 8, 0, 8);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= awvalid; end
    chk("init_gate", seen, 0);
    init_end = 1'b1;
    consume(v, 8);

    // Table of commands.
    for (int i = 0; i < 6; i++) begin
      push_cmd(tbl[i]);
      fork
        produce(tbl[i], i, 0, int'(tbl[i].len) + 1);
        consume(tbl[i], i);
      join
      chk("err_odd", usr_err_odd, tbl[i].err);
    end

    // Data starvation: only 3 of 8 beats available.
    v = mkv(A(4,100,64), 8'd7, 3'd1, A(4,100,64), '0, '0, '0, 8'd7, 0, 0, 0, 1'b1);
    push_cmd(v);
    produce(v, 9, 0, 3);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= awvalid; end
    chk("starve_gate", seen, 0);
    fork
      produce(v, 9, 3, 8);
      consume(v, 9);
    join

    // Reset in the middle of the data phase.
    v = mkv(A(5,6,0), 8'd15, 3'd1, A(5,6,0), '0, '0, '0, 8'd15, 0, 0, 0, 1'b1);
    push_cmd(v);
    produce(v, 10, 0, 16);
    t = 0;
    while (!awvalid && t < 500) begin @(negedge clk); t++; end
    chk("rst_awvalid", awvalid, 1);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {usr_cmd_ready, usr_wready, usr_done, usr_err_odd, awvalid, wvalid, wlast, bready, awaddr, awlen, wdata},
        58'h0);
    wready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= (usr_done | awvalid | wvalid); end
    chk("post_reset_idle", seen, 0);
    chk("post_reset_ready", {usr_cmd_ready, usr_wready, usr_err_odd}, 3'b110);

    // Fresh command completes normally after reset.
    v = mkv(A(6,1,512), 8'd5, 3'd1, A(6,1,512), '0, '0, '0, 8'd5, 0, 0, 0, 1'b0);
    push_cmd(v);
    fork
      produce(v, 11, 0, 6);
      consume(v, 11);
    join
    chk("fresh_err_odd", usr_err_odd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
